// File: rtl/axi_reg_pipe_if.sv
// AXI interface carrying the five channels used by the register pipe.
// Only the fields that the pipe forwards are present.
interface axi_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [STROBE_WIDTH-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wuser, wvalid, input wready,
        input bresp, buser, bvalid, output bready,
        output araddr, arlen, arvalid, input arready,
        input rdata, rresp, rlast, ruser, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awvalid, output awready,
        input wdata, wstrb, wlast, wuser, wvalid, output wready,
        output bresp, buser, bvalid, input bready,
        input araddr, arlen, arvalid, output arready,
        output rdata, rresp, rlast, ruser, rvalid, input rready
    );
endinterface

// File: rtl/axi_reg_pipe.sv
// Configurable per-channel register pipeline between two AXI ports.
// Each channel is bypassed, forward-registered or full-skid, STAGES slices deep.

module axi_fwd_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load;

    always_comb begin
        in_ready = !vld_q || out_ready;
        load     = in_valid && in_ready;
        vld_d    = vld_q;
        data_d   = data_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign empty     = !vld_q;
endmodule

module axi_skid_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    always_comb begin
        in_fire  = in_valid && in_ready_q;
        out_fire = (state_q != EMPTY) && out_ready;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain case exists
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign empty     = (state_q == EMPTY);
endmodule

module axi_slice_chain #(
    parameter int WIDTH  = 8,
    parameter int MODE   = 2,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;
    logic [WIDTH-1:0]  dat [STAGES+1];
    logic [STAGES-1:0] stage_empty;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign in_ready    = rdy[0];
    assign out_valid   = vld[STAGES];
    assign out_data    = dat[STAGES];
    assign rdy[STAGES] = out_ready;
    assign empty       = &stage_empty;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (MODE == 1) begin : g_fwd
            axi_fwd_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst),
                .in_valid(vld[k]), .in_ready(rdy[k]), .in_data(dat[k]),
                .out_valid(vld[k+1]), .out_ready(rdy[k+1]), .out_data(dat[k+1]),
                .empty(stage_empty[k])
            );
        end else begin : g_skid
            axi_skid_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst),
                .in_valid(vld[k]), .in_ready(rdy[k]), .in_data(dat[k]),
                .out_valid(vld[k+1]), .out_ready(rdy[k+1]), .out_data(dat[k+1]),
                .empty(stage_empty[k])
            );
        end
    end
endmodule

module axi_reg_pipe #(
    parameter int STAGES  = 1,
    parameter int AW_MODE = 2,
    parameter int W_MODE  = 2,
    parameter int B_MODE  = 1,
    parameter int AR_MODE = 2,
    parameter int R_MODE  = 2
) (
    input  logic  clk,
    input  logic  rst,
    axi_if.slave  s_axi,
    axi_if.master m_axi,
    output logic  idle
);
    localparam int AW_W = $bits(s_axi.awlen) + $bits(s_axi.awaddr);
    localparam int W_W  = $bits(s_axi.wuser) + 1 + $bits(s_axi.wstrb) + $bits(s_axi.wdata);
    localparam int B_W  = $bits(s_axi.buser) + $bits(s_axi.bresp);
    localparam int AR_W = $bits(s_axi.arlen) + $bits(s_axi.araddr);
    localparam int R_W  = $bits(s_axi.ruser) + $bits(s_axi.rresp) + 1 + $bits(s_axi.rdata);

    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in, r_out;
    logic [4:0]      ch_empty;

    assign aw_in = {s_axi.awlen, s_axi.awaddr};
    assign {m_axi.awlen, m_axi.awaddr} = aw_out;
    assign w_in  = {s_axi.wuser, s_axi.wlast, s_axi.wstrb, s_axi.wdata};
    assign {m_axi.wuser, m_axi.wlast, m_axi.wstrb, m_axi.wdata} = w_out;
    assign b_in  = {m_axi.buser, m_axi.bresp};
    assign {s_axi.buser, s_axi.bresp} = b_out;
    assign ar_in = {s_axi.arlen, s_axi.araddr};
    assign {m_axi.arlen, m_axi.araddr} = ar_out;
    assign r_in  = {m_axi.ruser, m_axi.rresp, m_axi.rlast, m_axi.rdata};
    assign {s_axi.ruser, s_axi.rresp, s_axi.rlast, s_axi.rdata} = r_out;

    if (AW_MODE == 0) begin : g_aw_bypass
        assign m_axi.awvalid = s_axi.awvalid;
        assign s_axi.awready = m_axi.awready;
        assign aw_out        = aw_in;
        assign ch_empty[0]   = 1'b1;
    end else begin : g_aw
        axi_slice_chain #(.WIDTH(AW_W), .MODE(AW_MODE), .STAGES(STAGES)) u_chain (
            .clk(clk), .rst(rst),
            .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
            .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out),
            .empty(ch_empty[0])
        );
    end

    if (W_MODE == 0) begin : g_w_bypass
        assign m_axi.wvalid = s_axi.wvalid;
        assign s_axi.wready = m_axi.wready;
        assign w_out        = w_in;
        assign ch_empty[1]  = 1'b1;
    end else begin : g_w
        axi_slice_chain #(.WIDTH(W_W), .MODE(W_MODE), .STAGES(STAGES)) u_chain (
            .clk(clk), .rst(rst),
            .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
            .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out),
            .empty(ch_empty[1])
        );
    end

    // Response channels run downstream-to-upstream
    if (B_MODE == 0) begin : g_b_bypass
        assign s_axi.bvalid = m_axi.bvalid;
        assign m_axi.bready = s_axi.bready;
        assign b_out        = b_in;
        assign ch_empty[2]  = 1'b1;
    end else begin : g_b
        axi_slice_chain #(.WIDTH(B_W), .MODE(B_MODE), .STAGES(STAGES)) u_chain (
            .clk(clk), .rst(rst),
            .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
            .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out),
            .empty(ch_empty[2])
        );
    end

    if (AR_MODE == 0) begin : g_ar_bypass
        assign m_axi.arvalid = s_axi.arvalid;
        assign s_axi.arready = m_axi.arready;
        assign ar_out        = ar_in;
        assign ch_empty[3]   = 1'b1;
    end else begin : g_ar
        axi_slice_chain #(.WIDTH(AR_W), .MODE(AR_MODE), .STAGES(STAGES)) u_chain (
            .clk(clk), .rst(rst),
            .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
            .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out),
            .empty(ch_empty[3])
        );
    end

    if (R_MODE == 0) begin : g_r_bypass
        assign s_axi.rvalid = m_axi.rvalid;
        assign m_axi.rready = s_axi.rready;
        assign r_out        = r_in;
        assign ch_empty[4]  = 1'b1;
    end else begin : g_r
        axi_slice_chain #(.WIDTH(R_W), .MODE(R_MODE), .STAGES(STAGES)) u_chain (
            .clk(clk), .rst(rst),
            .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
            .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out),
            .empty(ch_empty[4])
        );
    end

    assign idle = &ch_empty;
endmodule

// File: tb/tb_axi_reg_pipe.sv
// Bench for axi_reg_pipe: directed steps plus random traffic against
// per-channel in-order scoreboards with capacity and latency rules.
module tb_axi_reg_pipe;
    localparam int STG = 2;
    localparam int MODE [5] = '{2, 2, 0, 2, 1};   // aw, w, b, ar, r
    localparam logic [63:0] MASK [5] = '{64'hFF_FFFF_FFFF, 64'h1FF_FFFF_FFFF, 64'h3F,
                                         64'hFF_FFFF_FFFF, 64'h7F_FFFF_FFFF};
    string NAME [5] = '{"aw", "w", "b", "ar", "r"};

    logic clk = 1'b0;
    logic rst;
    logic idle;
    always #5 clk = ~clk;

    axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .USER_WIDTH(4)) s_if ();
    axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .USER_WIDTH(4)) m_if ();

    axi_reg_pipe #(
        .STAGES(STG), .AW_MODE(2), .W_MODE(2), .B_MODE(0), .AR_MODE(2), .R_MODE(1)
    ) dut (
        .clk(clk), .rst(rst), .s_axi(s_if), .m_axi(m_if), .idle(idle)
    );

    logic [4:0]  in_v, out_r, obs_out_v, obs_in_rdy;
    logic [63:0] in_d [5];
    logic [63:0] obs_out_d [5];

    assign s_if.awaddr = in_d[0][31:0];
    assign s_if.awlen  = in_d[0][39:32];
    assign s_if.awvalid = in_v[0];
    assign m_if.awready = out_r[0];
    assign s_if.wdata  = in_d[1][31:0];
    assign s_if.wstrb  = in_d[1][35:32];
    assign s_if.wlast  = in_d[1][36];
    assign s_if.wuser  = in_d[1][40:37];
    assign s_if.wvalid = in_v[1];
    assign m_if.wready = out_r[1];
    assign m_if.bresp  = in_d[2][1:0];
    assign m_if.buser  = in_d[2][5:2];
    assign m_if.bvalid = in_v[2];
    assign s_if.bready = out_r[2];
    assign s_if.araddr = in_d[3][31:0];
    assign s_if.arlen  = in_d[3][39:32];
    assign s_if.arvalid = in_v[3];
    assign m_if.arready = out_r[3];
    assign m_if.rdata  = in_d[4][31:0];
    assign m_if.rlast  = in_d[4][32];
    assign m_if.rresp  = in_d[4][34:33];
    assign m_if.ruser  = in_d[4][38:35];
    assign m_if.rvalid = in_v[4];
    assign s_if.rready = out_r[4];

    assign obs_out_v  = {s_if.rvalid, m_if.arvalid, s_if.bvalid, m_if.wvalid, m_if.awvalid};
    assign obs_in_rdy = {m_if.rready, s_if.arready, m_if.bready, s_if.wready, s_if.awready};
    assign obs_out_d[0] = {24'd0, m_if.awlen, m_if.awaddr};
    assign obs_out_d[1] = {23'd0, m_if.wuser, m_if.wlast, m_if.wstrb, m_if.wdata};
    assign obs_out_d[2] = {58'd0, s_if.buser, s_if.bresp};
    assign obs_out_d[3] = {24'd0, m_if.arlen, m_if.araddr};
    assign obs_out_d[4] = {25'd0, s_if.ruser, s_if.rresp, s_if.rlast, s_if.rdata};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          exact_lat = 1'b0;
    logic [63:0] sb [5][64];
    int          pcyc [5][64];
    int          head [5];
    int          tail [5];
    logic [4:0]  pend, fired_in, fired_out, prev_hold;
    logic [63:0] prev_d [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, update the model, return after the next rising edge.
    task automatic tick();
        int tot;
        int h;
        int cap;
        @(negedge clk);
        tot = 0;
        for (int c = 0; c < 5; c++) if (MODE[c] != 0) tot += tail[c] - head[c];
        chk("idle", 64'(idle), 64'(tot == 0));
        for (int c = 0; c < 5; c++) begin
            h = tail[c] - head[c];
            cap = (MODE[c] == 2) ? 2 * STG : STG;
            fired_in[c]  = in_v[c] && obs_in_rdy[c];
            fired_out[c] = obs_out_v[c] && out_r[c];
            if (MODE[c] == 0) begin
                chk({NAME[c], "_byp_valid"}, 64'(obs_out_v[c]), 64'(in_v[c]));
                chk({NAME[c], "_byp_data"}, obs_out_d[c], in_d[c] & MASK[c]);
                chk({NAME[c], "_byp_ready"}, 64'(obs_in_rdy[c]), 64'(out_r[c]));
            end else begin
                if (obs_out_v[c]) begin
                    chk({NAME[c], "_spurious"}, 64'(h == 0), 64'd0);
                    if (h > 0) begin
                        chk({NAME[c], "_data"}, obs_out_d[c], sb[c][head[c] % 64]);
                        chk({NAME[c], "_lat_min"}, 64'((cyc - pcyc[c][head[c] % 64]) >= STG), 64'd1);
                        if (exact_lat)
                            chk({NAME[c], "_lat"}, 64'(cyc - pcyc[c][head[c] % 64]), 64'(STG));
                    end
                end
                if (prev_hold[c]) begin
                    chk({NAME[c], "_hold_valid"}, 64'(obs_out_v[c]), 64'd1);
                    chk({NAME[c], "_hold_data"}, obs_out_d[c], prev_d[c]);
                end
                if (MODE[c] == 1)
                    chk({NAME[c], "_fwd_ready"}, 64'(obs_in_rdy[c]), 64'((h < STG) || out_r[c]));
                else if (h == cap)
                    chk({NAME[c], "_full_ready"}, 64'(obs_in_rdy[c]), 64'd0);
                if (!rst) begin
                    if (fired_out[c] && h > 0) head[c]++;
                    if (fired_in[c]) begin
                        sb[c][tail[c] % 64] = in_d[c] & MASK[c];
                        pcyc[c][tail[c] % 64] = cyc;
                        tail[c]++;
                    end
                    chk({NAME[c], "_capacity"}, 64'((tail[c] - head[c]) <= cap), 64'd1);
                end else begin
                    head[c] = tail[c];
                end
                prev_hold[c] = !rst && obs_out_v[c] && !out_r[c];
                prev_d[c] = obs_out_d[c];
            end
            pend[c] = !rst && in_v[c] && !fired_in[c];
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int k;
    int cnt [5];

    initial begin
        rst = 1'b1;
        in_v = '0;
        out_r = '0;
        pend = '0;
        prev_hold = '0;
        for (int c = 0; c < 5; c++) begin
            in_d[c] = '0;
            prev_d[c] = '0;
            head[c] = 0;
            tail[c] = 0;
            cnt[c] = 0;
        end

        // reset state
        @(posedge clk);
        #1;
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("rst_rvalid", 64'(s_if.rvalid), 64'd0);
        chk("rst_awready", 64'(s_if.awready), 64'd0);
        chk("rst_arready", 64'(s_if.arready), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_arready", 64'(s_if.arready), 64'd1);
        chk("post_rst_wready", 64'(s_if.wready), 64'd1);

        // single AW beat through an empty pipe
        out_r = '1;
        in_v[0] = 1'b1;
        in_d[0] = {24'd0, 8'd3, 32'h0000_1000};
        tick();
        in_v[0] = 1'b0;
        chk("aw_lat1_valid", 64'(m_if.awvalid), 64'd0);
        chk("aw_lat1_idle", 64'(idle), 64'd0);
        tick();
        chk("aw_out_valid", 64'(m_if.awvalid), 64'd1);
        chk("aw_out_addr", 64'(m_if.awaddr), 64'h1000);
        chk("aw_out_len", 64'(m_if.awlen), 64'd3);
        chk("aw_out_idle", 64'(idle), 64'd0);
        tick();
        chk("aw_done_idle", 64'(idle), 64'd1);
        chk("aw_done_valid", 64'(m_if.awvalid), 64'd0);

        // W stalled downstream: fills to 2*STAGES, then drains in order
        out_r[1] = 1'b0;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            in_v[1] = (k < 10);
            in_d[1] = 64'(k);
            tick();
            if (fired_in[1]) k++;
        end
        chk("w_stall_accepted", 64'(k), 64'(2 * STG));
        chk("w_stall_ready", 64'(s_if.wready), 64'd0);
        out_r[1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_v[1] = (k < 10);
            in_d[1] = 64'(k);
            tick();
            if (fired_in[1]) k++;
        end
        in_v[1] = 1'b0;
        chk("w_total_accepted", 64'(k), 64'd10);

        // reset while AR holds three beats
        out_r = '0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            in_v[3] = (k < 3);
            in_d[3] = {24'd0, 8'(k), 32'h2000 + 32'(k)};
            tick();
            if (fired_in[3]) k++;
        end
        in_v[3] = 1'b0;
        chk("ar_loaded", 64'(k), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ar_rst_valid", 64'(m_if.arvalid), 64'd0);
        chk("ar_rst_idle", 64'(idle), 64'd1);
        tick();
        chk("ar_rst_ready", 64'(s_if.arready), 64'd1);

        // random traffic on every channel, R ready toggling
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 5; c++) begin
                if (!pend[c]) begin
                    in_v[c] = ($urandom_range(0, 99) < 60);
                    in_d[c] = {$urandom, $urandom} & MASK[c];
                end
                out_r[c] = (c == 4) ? ((i % 2) == 0) : ($urandom_range(0, 99) < 70);
            end
            tick();
        end

        // drain, then sustained full-rate traffic with readies tied high
        in_v = '0;
        out_r = '1;
        repeat (12) tick();
        exact_lat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_v = '1;
            for (int c = 0; c < 5; c++) in_d[c] = {$urandom, $urandom} & MASK[c];
            tick();
            if (i >= 10) for (int c = 0; c < 5; c++) cnt[c] += int'(fired_out[c]);
        end
        exact_lat = 1'b0;
        for (int c = 0; c < 5; c++) chk({NAME[c], "_full_rate"}, 64'(cnt[c]), 64'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
